dec_stage: RTL and testbench

- Parameterised, buffered RV32I instruction-decode stage between fetch and execute.
- Accepts raw instructions with their PC over a valid/ready handshake, decodes them at enqueue, and stores the decoded bundles in a DEPTH-entry FIFO.
- Decode covers register-address fields, opcode/funct fields, instruction format, sign-extended immediate and an illegal-instruction flag.
- Supports pipeline flush and back-pressure from execute.

---
 rtl/dec_stage.sv | 153 +++++++++++++++
 tb/tb_dec_stage.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/dec_stage.sv
// Buffered RV32I decode stage: instructions are decoded on enqueue and held
// in a DEPTH-entry FIFO whose head drives all outputs directly from registers.
module dec_stage #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 2,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_inst,
  input  logic [XLEN-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [REG_AW-1:0] out_rs1,
  output logic [REG_AW-1:0] out_rs2,
  output logic [REG_AW-1:0] out_rd,
  output logic [6:0]        out_opcode,
  output logic [2:0]        out_funct3,
  output logic [6:0]        out_funct7,
  output logic [XLEN-1:0]   out_imm,
  output logic [2:0]        out_fmt,
  output logic              out_illegal
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [2:0] FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2, FMT_B = 3'd3,
                         FMT_U = 3'd4, FMT_J = 3'd5, FMT_X = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [XLEN-1:0]   imm;
    logic [2:0]        fmt;
    logic              illegal;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] inst, input logic [XLEN-1:0] pc);
    dec_t        d;
    logic [31:0] imm32;
    d        = '0;
    imm32    = '0;
    d.pc     = pc;
    d.rs1    = REG_AW'(inst[19:15]);
    d.rs2    = REG_AW'(inst[24:20]);
    d.rd     = REG_AW'(inst[11:7]);
    d.opcode = inst[6:0];
    d.funct3 = inst[14:12];
    d.funct7 = inst[31:25];
    d.fmt    = FMT_X;
    if (inst[1:0] == 2'b11) begin
      case (inst[6:0])
        7'b0110011: d.fmt = FMT_R;
        7'b0010011, 7'b0000011, 7'b1100111,
        7'b1110011, 7'b0001111: begin
          d.fmt = FMT_I;
          imm32 = {{20{inst[31]}}, inst[31:20]};
        end
        7'b0100011: begin
          d.fmt = FMT_S;
          imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        end
        7'b1100011: begin
          d.fmt = FMT_B;
          imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        end
        7'b0110111, 7'b0010111: begin
          d.fmt = FMT_U;
          imm32 = {inst[31:12], 12'b0};
        end
        7'b1101111: begin
          d.fmt = FMT_J;
          imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        end
        default: d.fmt = FMT_X;
      endcase
    end
    d.illegal = (d.fmt == FMT_X);
    // imm32 is already sign-correct; widen by replicating its MSB
    d.imm = XLEN'($signed(imm32));
    return d;
  endfunction

  dec_t            mem_q [DEPTH];
  dec_t            in_dec;
  dec_t            head;
  logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            accept, pop;

  assign in_ready  = (cnt_q < CW'(DEPTH));
  assign out_valid = (cnt_q != '0);
  assign accept    = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  assign in_dec    = decode(in_inst, in_pc);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (accept) wptr_d = (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + PW'(1);
      if (pop)    rptr_d = (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + PW'(1);
      case ({accept, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Storage is cleared on reset so the head outputs read zero afterwards
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      if (accept) mem_q[wptr_q] <= in_dec;
    end
  end

  assign head        = mem_q[rptr_q];
  assign out_pc      = head.pc;
  assign out_rs1     = head.rs1;
  assign out_rs2     = head.rs2;
  assign out_rd      = head.rd;
  assign out_opcode  = head.opcode;
  assign out_funct3  = head.funct3;
  assign out_funct7  = head.funct7;
  assign out_imm     = head.imm;
  assign out_fmt     = head.fmt;
  assign out_illegal = head.illegal;

endmodule

// File: tb/tb_dec_stage.sv
// Directed bench for dec_stage: decode vector table plus streaming,
// back-pressure, flush and reset sequences.
module tb_dec_stage;

  localparam int XLEN = 32, DEPTH = 2, REG_AW = 5;

  logic              clk = 1'b0;
  logic              rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0]       in_inst;
  logic [XLEN-1:0]   in_pc, out_pc, out_imm;
  logic [REG_AW-1:0] out_rs1, out_rs2, out_rd;
  logic [6:0]        out_opcode, out_funct7;
  logic [2:0]        out_funct3, out_fmt;

  int nchk = 0, nfail = 0;

  dec_stage #(.XLEN(XLEN), .DEPTH(DEPTH), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] inst, pc, input logic [4:0] rs1, rs2, rd,
                              input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] imm, input logic [2:0] fmt, input logic ill);
    vec_t v;
    v.inst = inst; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.op = op;
    v.f3 = f3; v.f7 = f7; v.imm = imm; v.fmt = fmt; v.ill = ill;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_head(input string tag, input vec_t v);
    chk({tag, ".valid"},  64'(out_valid),   64'd1);
    chk({tag, ".pc"},     64'(out_pc),      64'(v.pc));
    chk({tag, ".rs1"},    64'(out_rs1),     64'(v.rs1));
    chk({tag, ".rs2"},    64'(out_rs2),     64'(v.rs2));
    chk({tag, ".rd"},     64'(out_rd),      64'(v.rd));
    chk({tag, ".opcode"}, 64'(out_opcode),  64'(v.op));
    chk({tag, ".funct3"}, 64'(out_funct3),  64'(v.f3));
    chk({tag, ".funct7"}, 64'(out_funct7),  64'(v.f7));
    chk({tag, ".imm"},    64'(out_imm),     64'(v.imm));
    chk({tag, ".fmt"},    64'(out_fmt),     64'(v.fmt));
    chk({tag, ".illegal"},64'(out_illegal), 64'(v.ill));
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, pc);
    in_valid = v; in_inst = inst; in_pc = pc;
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".valid"},   64'(out_valid),   64'd0);
    chk({tag, ".ready"},   64'(in_ready),    64'd1);
    chk({tag, ".pc"},      64'(out_pc),      64'd0);
    chk({tag, ".imm"},     64'(out_imm),     64'd0);
    chk({tag, ".rd"},      64'(out_rd),      64'd0);
    chk({tag, ".rs1"},     64'(out_rs1),     64'd0);
    chk({tag, ".opcode"},  64'(out_opcode),  64'd0);
    chk({tag, ".fmt"},     64'(out_fmt),     64'd0);
    chk({tag, ".illegal"}, 64'(out_illegal), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[9];
    vec_t sw_v, beq_v, lui_v, va, vb, vc;
    //           inst          pc     rs1 rs2 rd  op     f3 f7     imm           fmt ill
    tbl[0] = mk(32'hFFF10093, 32'h10, 2, 31, 1, 7'h13, 0, 7'h7F, 32'hFFFFFFFF, 1, 0);
    tbl[1] = mk(32'h00512423, 32'h14, 2, 5,  8, 7'h23, 2, 7'h00, 32'h00000008, 2, 0);
    tbl[2] = mk(32'hFE000EE3, 32'h18, 0, 0, 29, 7'h63, 0, 7'h7F, 32'hFFFFFFFC, 3, 0);
    tbl[3] = mk(32'h123451B7, 32'h1C, 8, 3,  3, 7'h37, 5, 7'h09, 32'h12345000, 4, 0);
    tbl[4] = mk(32'h008000EF, 32'h20, 0, 8,  1, 7'h6F, 0, 7'h00, 32'h00000008, 5, 0);
    tbl[5] = mk(32'h00000000, 32'h24, 0, 0,  0, 7'h00, 0, 7'h00, 32'h00000000, 7, 1);
    tbl[6] = mk(32'h0000007F, 32'h28, 0, 0,  0, 7'h7F, 0, 7'h00, 32'h00000000, 7, 1);
    tbl[7] = mk(32'h002081B3, 32'h2C, 1, 2,  3, 7'h33, 0, 7'h00, 32'h00000000, 0, 0);
    tbl[8] = mk(32'h00000010, 32'h30, 0, 0,  0, 7'h10, 0, 7'h00, 32'h00000000, 7, 1);

    rst_n = 0; flush = 0; out_ready = 0;
    drive(0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk_zero("reset");

    // Single-instruction decode table; each enters an empty FIFO
    out_ready = 1;
    foreach (tbl[i]) begin
      drive(1, tbl[i].inst, tbl[i].pc);
      step();
      drive(0, 0, 0);
      @(negedge clk);
      chk_head($sformatf("vec%0d", i), tbl[i]);
      step();
    end
    @(negedge clk);
    chk("drained.valid", 64'(out_valid), 64'd0);

    // Back-to-back stream, no bubbles
    sw_v  = tbl[1]; sw_v.pc  = 32'h100;
    beq_v = tbl[2]; beq_v.pc = 32'h104;
    lui_v = tbl[3]; lui_v.pc = 32'h108;
    drive(1, sw_v.inst, sw_v.pc);   step();
    drive(1, beq_v.inst, beq_v.pc); @(negedge clk); chk_head("stream.sw", sw_v);   step();
    drive(1, lui_v.inst, lui_v.pc); @(negedge clk); chk_head("stream.beq", beq_v); step();
    drive(0, 0, 0);                 @(negedge clk); chk_head("stream.lui", lui_v); step();
    @(negedge clk);
    chk("stream.empty", 64'(out_valid), 64'd0);

    // Back-pressure: third instruction held while full
    va = tbl[0]; va.pc = 32'h200;
    vb = tbl[7]; vb.pc = 32'h204;
    vc = tbl[3]; vc.pc = 32'h208;
    out_ready = 0;
    drive(1, va.inst, va.pc); step();
    drive(1, vb.inst, vb.pc); step();
    drive(1, vc.inst, vc.pc);
    @(negedge clk);
    chk("bp.full_ready", 64'(in_ready), 64'd0);
    chk_head("bp.headA", va);
    step();
    @(negedge clk);
    chk("bp.still_full", 64'(in_ready), 64'd0);
    chk_head("bp.stableA", va);
    out_ready = 1; step(); out_ready = 0;
    @(negedge clk);
    chk("bp.ready_after_pop", 64'(in_ready), 64'd1);
    chk_head("bp.headB", vb);
    step();
    drive(0, 0, 0);
    @(negedge clk);
    chk("bp.full_again", 64'(in_ready), 64'd0);
    chk_head("bp.headB2", vb);
    out_ready = 1; step();
    @(negedge clk); chk_head("bp.headC", vc); step();
    @(negedge clk); chk("bp.empty", 64'(out_valid), 64'd0);

    // Flush while full with in_valid, then flush with room available
    out_ready = 0;
    drive(1, va.inst, 32'h300); step();
    drive(1, va.inst, 32'h304); step();
    drive(1, va.inst, 32'h308); flush = 1; step(); flush = 0;
    drive(0, 0, 0);
    @(negedge clk);
    chk("flush.valid", 64'(out_valid), 64'd0);
    chk("flush.ready", 64'(in_ready), 64'd1);
    drive(1, va.inst, 32'h400); step();
    drive(1, va.inst, 32'h404); flush = 1; step(); flush = 0;
    drive(1, va.inst, 32'h408); out_ready = 1; step();
    drive(0, 0, 0);
    @(negedge clk);
    chk("flush2.pc", 64'(out_pc), 64'h408);
    chk("flush2.valid", 64'(out_valid), 64'd1);
    step();
    @(negedge clk);
    chk("flush2.empty", 64'(out_valid), 64'd0);

    // Reset mid-stream with two entries and in_valid high
    out_ready = 0;
    drive(1, tbl[3].inst, 32'h500); step();
    drive(1, tbl[3].inst, 32'h504); step();
    drive(1, tbl[3].inst, 32'h508); rst_n = 0; step(); rst_n = 1;
    drive(0, 0, 0);
    @(negedge clk);
    chk_zero("midrst");

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
    $finish;
  end

endmodule
